fwd_hazard_unit: RTL
====================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL provide parameter NUM_SRC, default 2, number of source operands per instruction (1..4).
REQ-002 The block SHALL provide parameter RAW, default 5, register-address width.
REQ-003 The block SHALL provide parameter MC_MAXLAT, default 34, maximum multi-cycle latency; watchdog limit in cycles.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 ex_rs  in  NUM_SRC*RAW  source addresses of the instruction in EX; slot i at bits [i*RAW +: RAW].
REQ-007 id_rs  in  NUM_SRC*RAW  source addresses of the instruction in ID.
REQ-008 id_rs_used  in  NUM_SRC  per-slot flag: ID instruction reads slot i.
REQ-009 id_is_mc  in  1  ID instruction is a multi-cycle op (mul/div).
REQ-010 ex_rd, ex_regwrite, ex_memread  in  RAW,1,1  EX-stage destination, write enable, and load flag.
REQ-011 mem_rd, mem_regwrite  in  RAW,1  EX/MEM destination and write enable.
REQ-012 wb_rd, wb_regwrite  in  RAW,1  MEM/WB destination and write enable.
REQ-013 mc_start, mc_rd  in  1,RAW  multi-cycle op issued this cycle and its destination.
REQ-014 mc_done  in  1  multi-cycle result valid this cycle.
REQ-015 fwd_sel  out  2*NUM_SRC  per EX slot: 00 regfile, 01 WB, 10 MEM, 11 MC result.
REQ-016 stall  out  1  hold PC and IF/ID and insert a bubble into EX.
REQ-017 mc_busy  out  1  multi-cycle unit occupied.
REQ-018 mc_err  out  1  sticky protocol/timeout error.

Function
REQ-019 fwd_sel SHALL be combinational per slot, with priority MC (mc_done && mc_rd==slot) > MEM (mem_regwrite && mem_rd==slot) > WB (wb_regwrite && wb_rd==slot) > regfile.
REQ-020 A slot address of 0 SHALL always yield fwd_sel 00.
REQ-021 Load-use: stall SHALL be 1 when ex_memread && ex_regwrite && ex_rd!=0 && ex_rd equals any id_rs slot with id_rs_used set.
REQ-022 The FSM SHALL have states IDLE and BUSY; it SHALL leave reset in IDLE.
REQ-023 IDLE->BUSY SHALL occur on mc_start; the block SHALL latch mc_rd into pend_rd and clear lat_cnt to 0.
REQ-024 BUSY->IDLE SHALL occur on mc_done without mc_start.
REQ-025 mc_done together with mc_start in BUSY SHALL keep the FSM in BUSY with the new pend_rd and lat_cnt cleared.
REQ-026 In BUSY, stall SHALL be 1 if id_is_mc is set (structural hazard), or if pend_rd!=0 and pend_rd matches a used id_rs slot, unless mc_done is asserted in the same cycle and the match is against that pend_rd.
REQ-027 mc_start in BUSY without mc_done SHALL be ignored and SHALL set mc_err.
REQ-028 mc_done in IDLE SHALL be ignored and SHALL set mc_err.
REQ-029 lat_cnt SHALL increment each BUSY cycle and saturate.
REQ-030 lat_cnt reaching MC_MAXLAT SHALL set mc_err and force IDLE.
REQ-031 mc_busy SHALL equal (state==BUSY), registered.
REQ-032 mc_err SHALL be sticky until reset.

Reset
REQ-033 rst_n low SHALL asynchronously force state IDLE, pend_rd 0, lat_cnt 0, mc_err 0, and mc_busy 0.
REQ-034 During reset, stall SHALL be 0 and fwd_sel all 00.
REQ-035 Reset asserted mid-BUSY SHALL abandon the pending op with no error.

Configuration
REQ-036 With HAZ_PERF_CNT_EN defined, the block SHALL add outputs stall_cnt (32-bit) and mc_cnt (32-bit): stall_cnt counts cycles with stall=1, mc_cnt counts accepted mc_start events; both wrap at 2^32 and reset to 0.
REQ-037 Without HAZ_PERF_CNT_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-038 Scenario: mem_regwrite=1, mem_rd=5, wb_regwrite=1, wb_rd=5, ex_rs slot0=5 -> fwd_sel[1:0]=10.
REQ-039 Scenario: ex_rs slot1=0 with mem_rd=0 and mem_regwrite=1 -> fwd_sel[3:2]=00.
REQ-040 Scenario: ex_memread=1, ex_rd=7, id_rs slot1=7 with id_rs_used=2'b10 -> stall=1; same inputs with id_rs_used=2'b01 -> stall=0.
REQ-041 Scenario: mc_start with mc_rd=9, then id_rs slot0=9 used for 3 cycles, then mc_done -> stall=1 for 3 cycles, 0 on the mc_done cycle; mc_busy drops the following cycle; fwd_sel=11 for an EX slot of 9 on the mc_done cycle.
REQ-042 Scenario: mc_start, then no mc_done for MC_MAXLAT cycles -> mc_err=1, state IDLE, mc_busy=0.
REQ-043 Scenario: rst_n pulsed low mid-BUSY -> mc_busy=0 and mc_err=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding select, load-use and multi-cycle hazard stall, MC watchdog.
// Optional HAZ_PERF_CNT_EN adds stall_cnt / mc_cnt performance counters.
`timescale 1ns/1ps
module fwd_hazard_unit #(
  parameter int NUM_SRC   = 2,
  parameter int RAW       = 5,
  parameter int MC_MAXLAT = 34
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC*RAW-1:0] ex_rs,
  input  logic [NUM_SRC*RAW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]     id_rs_used,
  input  logic                   id_is_mc,
  input  logic [RAW-1:0]         ex_rd,
  input  logic                   ex_regwrite,
  input  logic                   ex_memread,
  input  logic [RAW-1:0]         mem_rd,
  input  logic                   mem_regwrite,
  input  logic [RAW-1:0]         wb_rd,
  input  logic                   wb_regwrite,
  input  logic                   mc_start,
  input  logic [RAW-1:0]         mc_rd,
  input  logic                   mc_done,
  output logic [2*NUM_SRC-1:0]   fwd_sel,
  output logic                   stall,
  output logic                   mc_busy,
  output logic                   mc_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            mc_cnt
`endif
);
  localparam int LW = $clog2(MC_MAXLAT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t         state_q, state_d;
  logic [RAW-1:0] pend_q, pend_d;
  logic [LW-1:0]  lat_q, lat_d;
  logic           err_d, ld_hit, pend_hit;
  always_comb begin
    fwd_sel  = '0;
    ld_hit   = 1'b0;
    pend_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_sel[2*i +: 2] = (!rst_n || ex_rs[i*RAW +: RAW] == '0) ? 2'b00 :
                          (mc_done && mc_rd == ex_rs[i*RAW +: RAW]) ? 2'b11 :
                          (mem_regwrite && mem_rd == ex_rs[i*RAW +: RAW]) ? 2'b10 :
                          (wb_regwrite && wb_rd == ex_rs[i*RAW +: RAW]) ? 2'b01 : 2'b00;
      ld_hit   = ld_hit | (id_rs_used[i] && id_rs[i*RAW +: RAW] == ex_rd);
      pend_hit = pend_hit | (id_rs_used[i] && id_rs[i*RAW +: RAW] == pend_q);
    end
  end
  // A finishing op releases its own consumer in the same cycle via the MC bypass.
  assign stall = rst_n && ((ex_memread && ex_regwrite && ex_rd != '0 && ld_hit) ||
                 (state_q == BUSY && (id_is_mc || (pend_q != '0 && pend_hit && !mc_done))));
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    lat_d   = lat_q;
    err_d   = mc_err;
    if (state_q == IDLE) begin
      err_d = mc_err | mc_done;
      if (mc_start) begin
        state_d = BUSY;
        pend_d  = mc_rd;
        lat_d   = '0;
      end
    end else if (mc_done) begin
      lat_d   = '0;
      state_d = mc_start ? BUSY : IDLE;
      pend_d  = mc_start ? mc_rd : pend_q;
    end else begin
      err_d = mc_err | mc_start;
      lat_d = (lat_q == LW'(MC_MAXLAT)) ? lat_q : lat_q + LW'(1);
      if (lat_d == LW'(MC_MAXLAT)) begin
        err_d   = 1'b1;
        state_d = IDLE;
        lat_d   = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      lat_q   <= '0;
      mc_err  <= 1'b0;
      mc_busy <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      lat_q   <= lat_d;
      mc_err  <= err_d;
      mc_busy <= state_d == BUSY;
    end
  end
`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      mc_cnt    <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(stall);
      mc_cnt    <= mc_cnt + 32'(mc_start && (state_q == IDLE || mc_done));
    end
  end
`endif
endmodule
